// File: rtl/imem_loader_if.sv
// Byte-stream handshake into the instruction-memory loader.
// Ports: s_valid/s_data/s_last from source, s_ready back from loader.
interface imem_loader_if;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_last;
    logic       s_ready;

    modport master (
        output s_valid,
        output s_data,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_last,
        output s_ready
    );
endinterface

// File: rtl/imem_loader.sv
// Program loader: packs a big-endian byte stream into 32-bit words and
// writes them to instruction memory at consecutive addresses while the
// CPU is stalled.
// Ports: clk, rst_n (async low), start pulse, s (byte stream slave),
//   im_we/im_wa/im_wd (memory write port), cpu_stall, done, overflow,
//   word_count (words written by the last/current load).
module imem_loader #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    imem_loader_if.slave          s,
    output logic                  im_we,
    output logic [ADDR_WIDTH-1:0] im_wa,
    output logic [WIDTH-1:0]      im_wd,
    output logic                  cpu_stall,
    output logic                  done,
    output logic                  overflow,
    output logic [ADDR_WIDTH:0]   word_count
);

    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WRITE,
        DONE
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [1:0]      byte_idx_q;
    logic [WIDTH-1:0] word_q;
    logic [WIDTH-1:0] word_next;
    logic            last_q;
    logic            accept;
    logic            full;
    logic            ovf_hit;
    logic            finish_word;
    logic            restart;

    // s_ready is 1 exactly in LOAD, so a valid byte there is accepted.
    assign accept      = (state_q == LOAD) && s.s_valid;
    assign full        = (word_count == DEPTH_CNT);
    assign ovf_hit     = accept && full;
    assign finish_word = accept && !full &&
                         ((byte_idx_q == 2'd3) || s.s_last);
    assign restart     = start &&
                         ((state_q == IDLE) || (state_q == DONE));

    // Drop the incoming byte into its big-endian lane; lanes not yet
    // filled stay zero, which pads a short final word.
    always_comb begin
        word_next = word_q;
        unique case (byte_idx_q)
            2'd0: word_next[WIDTH-1  -: 8] = s.s_data;
            2'd1: word_next[WIDTH-9  -: 8] = s.s_data;
            2'd2: word_next[WIDTH-17 -: 8] = s.s_data;
            2'd3: word_next[WIDTH-25 -: 8] = s.s_data;
            default: word_next = word_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        s.s_ready = 1'b0;
        im_we     = 1'b0;
        cpu_stall = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                s.s_ready = 1'b1;
                cpu_stall = 1'b1;
                if (ovf_hit) begin
                    state_d = DONE;
                end else if (finish_word) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                im_we     = 1'b1;
                cpu_stall = 1'b1;
                state_d   = last_q ? DONE : LOAD;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_d = LOAD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath. im_wa/im_wd are captured when a word completes, so they
    // are stable through WRITE and hold afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx_q <= 2'd0;
            word_q     <= '0;
            last_q     <= 1'b0;
            overflow   <= 1'b0;
            word_count <= '0;
            im_wa      <= '0;
            im_wd      <= '0;
        end else begin
            if (restart) begin
                byte_idx_q <= 2'd0;
                word_q     <= '0;
                last_q     <= 1'b0;
                overflow   <= 1'b0;
                word_count <= '0;
            end
            if (ovf_hit) begin
                overflow <= 1'b1;
            end else if (finish_word) begin
                im_wd      <= word_next;
                im_wa      <= word_count[ADDR_WIDTH-1:0];
                last_q     <= s.s_last;
                word_q     <= '0;
                byte_idx_q <= 2'd0;
            end else if (accept) begin
                word_q     <= word_next;
                byte_idx_q <= byte_idx_q + 2'd1;
            end
            if (state_q == WRITE) begin
                word_count <= word_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (DEPTH=4 so the
// overflow path is reachable with a short stream).
module tb_imem_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        im_we;
    logic [7:0]  im_wa;
    logic [31:0] im_wd;
    logic        cpu_stall;
    logic        done;
    logic        overflow;
    logic [8:0]  word_count;

    imem_loader_if bus ();

    imem_loader #(
        .WIDTH(32),
        .ADDR_WIDTH(8),
        .DEPTH(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .s(bus),
        .im_we(im_we),
        .im_wa(im_wa),
        .im_wd(im_wd),
        .cpu_stall(cpu_stall),
        .done(done),
        .overflow(overflow),
        .word_count(word_count)
    );

    int tests;
    int failed;
    int acc_timeouts;
    int ready_in_write;
    logic [7:0]  wa_log[$];
    logic [31:0] wd_log[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (im_we === 1'b1) begin
            wa_log.push_back(im_wa);
            wd_log.push_back(im_wd);
            if (bus.s_ready !== 1'b0) ready_in_write++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one byte; returns once it is taken or the budget expires.
    task automatic send_try(input logic [7:0] d, input logic l,
                            input bit gap, input int budget,
                            output bit taken);
        int n;
        n = 0;
        if (gap) @(negedge clk);
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = l;
        while (bus.s_ready !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        taken = (bus.s_ready === 1'b1);
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic l, input bit gap);
        bit taken;
        send_try(d, l, gap, 20, taken);
        if (!taken) acc_timeouts++;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(done), 64'd1);
    endtask

    task automatic clear_logs();
        wa_log.delete();
        wd_log.delete();
    endtask

    initial begin
        bit taken;
        int n_taken;
        logic [7:0] ovf_bytes [20];

        tests = 0;
        failed = 0;
        acc_timeouts = 0;
        ready_in_write = 0;
        rst_n = 1'b0;
        start = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data = 8'h00;
        bus.s_last = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(bus.s_ready), 64'd0);
        chk("rst_outs", {im_we, cpu_stall, done, overflow},
            64'd0);
        chk("rst_bus", {im_wa, im_wd, word_count}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", 64'(bus.s_ready), 64'd0);

        // Single word
        clear_logs();
        pulse_start();
        chk("sw_ready_after_start", 64'(bus.s_ready), 64'd1);
        chk("sw_stall_after_start", 64'(cpu_stall), 64'd1);
        send(8'h20, 1'b0, 1'b0);
        send(8'h08, 1'b0, 1'b0);
        send(8'h00, 1'b0, 1'b0);
        send(8'h05, 1'b1, 1'b0);
        @(negedge clk);
        chk("sw_we", 64'(im_we), 64'd1);
        chk("sw_wa", 64'(im_wa), 64'd0);
        chk("sw_wd", 64'(im_wd), 64'h20080005);
        chk("sw_stall_write", 64'(cpu_stall), 64'd1);
        @(negedge clk);
        chk("sw_done", 64'(done), 64'd1);
        chk("sw_stall_done", 64'(cpu_stall), 64'd0);
        chk("sw_count", 64'(word_count), 64'd1);
        chk("sw_nwrites", 64'(wa_log.size()), 64'd1);

        // Three words, s_valid toggled every other cycle
        clear_logs();
        pulse_start();
        chk("tw_count_clr", 64'(word_count), 64'd0);
        for (int i = 1; i <= 12; i++) begin
            send(8'(i), (i == 12), 1'b1);
        end
        wait_done("tw_done");
        chk("tw_nwrites", 64'(wa_log.size()), 64'd3);
        if (wa_log.size() == 3) begin
            chk("tw_wa0", 64'(wa_log[0]), 64'd0);
            chk("tw_wd0", 64'(wd_log[0]), 64'h01020304);
            chk("tw_wa1", 64'(wa_log[1]), 64'd1);
            chk("tw_wd1", 64'(wd_log[1]), 64'h05060708);
            chk("tw_wa2", 64'(wa_log[2]), 64'd2);
            chk("tw_wd2", 64'(wd_log[2]), 64'h090A0B0C);
        end
        chk("tw_count", 64'(word_count), 64'd3);

        // Partial last word
        clear_logs();
        pulse_start();
        send(8'h8C, 1'b0, 1'b0);
        send(8'h09, 1'b0, 1'b0);
        send(8'h00, 1'b0, 1'b0);
        send(8'h04, 1'b0, 1'b0);
        send(8'hAC, 1'b0, 1'b0);
        send(8'h0A, 1'b1, 1'b0);
        wait_done("pw_done");
        chk("pw_nwrites", 64'(wa_log.size()), 64'd2);
        if (wa_log.size() == 2) begin
            chk("pw_wa0", 64'(wa_log[0]), 64'd0);
            chk("pw_wd0", 64'(wd_log[0]), 64'h8C090004);
            chk("pw_wa1", 64'(wa_log[1]), 64'd1);
            chk("pw_wd1", 64'(wd_log[1]), 64'hAC0A0000);
        end
        chk("pw_count", 64'(word_count), 64'd2);

        // Overflow: 5 words into a 4-word memory
        clear_logs();
        pulse_start();
        for (int i = 0; i < 20; i++) ovf_bytes[i] = 8'(8'h40 + i);
        n_taken = 0;
        for (int i = 0; i < 20; i++) begin
            send_try(ovf_bytes[i], (i == 19), 1'b0, 8, taken);
            if (taken) n_taken++;
        end
        chk("ov_taken", 64'(n_taken), 64'd17);
        chk("ov_nwrites", 64'(wa_log.size()), 64'd4);
        if (wa_log.size() == 4) begin
            chk("ov_wa3", 64'(wa_log[3]), 64'd3);
            chk("ov_wd0", 64'(wd_log[0]), 64'h40414243);
            chk("ov_wd3", 64'(wd_log[3]), 64'h4C4D4E4F);
        end
        chk("ov_flag", 64'(overflow), 64'd1);
        chk("ov_done", 64'(done), 64'd1);
        chk("ov_count", 64'(word_count), 64'd4);
        chk("ov_ready", 64'(bus.s_ready), 64'd0);

        // Restart; start during LOAD is ignored
        clear_logs();
        pulse_start();
        chk("rs_cleared", {done, overflow, word_count}, 64'd0);
        send(8'h11, 1'b0, 1'b0);
        send(8'h22, 1'b0, 1'b0);
        pulse_start();
        chk("rs_ign_stall", 64'(cpu_stall), 64'd1);
        chk("rs_ign_done", 64'(done), 64'd0);
        send(8'h33, 1'b0, 1'b0);
        send(8'h44, 1'b1, 1'b0);
        wait_done("rs_done");
        chk("rs_nwrites", 64'(wa_log.size()), 64'd1);
        if (wa_log.size() == 1) begin
            chk("rs_wa", 64'(wa_log[0]), 64'd0);
            chk("rs_wd", 64'(wd_log[0]), 64'h11223344);
        end
        chk("rs_count", 64'(word_count), 64'd1);

        // Reset mid-load with two bytes pending
        clear_logs();
        pulse_start();
        send(8'hAA, 1'b0, 1'b0);
        send(8'hBB, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mr_ready", 64'(bus.s_ready), 64'd0);
        chk("mr_outs", {im_we, cpu_stall, done, overflow}, 64'd0);
        chk("mr_bus", {im_wa, im_wd, word_count}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mr_idle_ready", 64'(bus.s_ready), 64'd0);
        chk("mr_idle_stall", 64'(cpu_stall), 64'd0);
        chk("mr_nwrites", 64'(wa_log.size()), 64'd0);

        // Partial word was abandoned: fresh load packs cleanly
        pulse_start();
        send(8'hDE, 1'b0, 1'b0);
        send(8'hAD, 1'b0, 1'b0);
        send(8'hBE, 1'b0, 1'b0);
        send(8'hEF, 1'b1, 1'b0);
        wait_done("pr_done");
        chk("pr_nwrites", 64'(wa_log.size()), 64'd1);
        if (wa_log.size() == 1) begin
            chk("pr_wd", 64'(wd_log[0]), 64'hDEADBEEF);
        end

        chk("ready_in_write", 64'(ready_in_write), 64'd0);
        chk("accept_timeouts", 64'(acc_timeouts), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
